mnist_result_uart_tx: RTL and testbench
=======================================

Name: mnist_result_uart_tx

Overview:
Transmit-side result reporter for the MNIST accelerator. It accepts one classification result (class index plus per-class scores) through a valid/ready handshake and serialises it as a fixed-length framed packet on a UART TX line, 8N1, LSB first. It has its own bit-timing counter and shift logic, with no dependency on any external serialiser. It sits between the inference core's output stage and the board TX pin; the host parses frames by header and checksum.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
UART_BPS, 115200, baud rate; bit period BPS_CNT = CLK_FREQ/UART_BPS (integer division; 217 at defaults)
NUM_CLASS, 10, number of score bytes per frame

Ports:
sys_clk  input  1  system clock, rising-edge
sys_rst  input  1  asynchronous, active-high reset
result_valid  input  1  result available
result_ready  output  1  block idle and able to accept a result
result_class  input  4  predicted class index
result_scores  input  8*NUM_CLASS  score k at bits [8k+7:8k], unsigned
uart_txd  output  1  serial line, idle high
tx_busy  output  1  frame in progress

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset is asynchronous and active-high on sys_rst.
- Reset values: uart_txd=1, result_ready=1, tx_busy=0, FSM=IDLE, all counters=0.
- Handshake:
  - Transfer occurs on a rising edge with result_valid&&result_ready.
  - result_class and result_scores are registered on that edge; inputs are ignored for the rest of the frame.
  - result_ready=0 and tx_busy=1 from the next cycle until the frame completes.
- Frame format: NUM_CLASS+4 bytes (14 at defaults), in this order:
  - 0xAA
  - 0x55
  - {4'b0, class}
  - score[0] .. score[NUM_CLASS-1]
  - checksum = (class + sum of scores) mod 256
- Checksum: computed with an 8-bit wrapping accumulator. Header bytes are excluded.
- Class values: class values >9 are sent unchanged; no range check.
- Bit timing:
  - Each byte is 10 bits: start 0, data[0..7], stop 1.
  - Every bit holds for exactly BPS_CNT clocks.
  - The start bit of the first byte drives uart_txd low in the first cycle after the handshake edge.
- Byte spacing: bytes are back-to-back. The stop bit of byte i is immediately followed by the start bit of byte i+1, with no idle gap.
- FSM: IDLE -> START -> DATA -> STOP, then:
  - STOP -> START if bytes remain
  - STOP -> IDLE after the last byte
  - Bit counter 0..7 runs in DATA; byte index runs 0..NUM_CLASS+3.
- Frame length: NUM_CLASS+4 bytes × 10 bits × BPS_CNT clocks (30380 clocks at defaults).
- Frame completion:
  - In the cycle after the last stop-bit clock: result_ready=1, tx_busy=0, uart_txd=1.
  - A new handshake is possible in that same cycle.
- Continuous valid: if result_valid is held high, the next frame starts immediately and the line stays high for exactly that one ready cycle.
- Reset mid-frame: uart_txd goes high asynchronously and the frame is abandoned. After release, the block is IDLE with result_ready=1. The next frame starts from 0xAA.
- Output registering: uart_txd is driven from a register (glitch-free).

Test Plan:
1. Reset: assert sys_rst for 5 cycles at random phase -> uart_txd=1, result_ready=1, tx_busy=0 immediately; state holds after release with result_valid=0.
2. Single frame, class=7, scores=0x00,0x01,..,0x09:
   - bytes AA 55 07 00 01 02 03 04 05 06 07 08 09 34 decoded LSB-first;
   - start bit falls 1 cycle after handshake;
   - each bit exactly 217 cycles;
   - result_ready returns after 30380 cycles.
3. Checksum wrap: class=9, all scores 0xFF -> checksum byte 0xFF; header, class and score bytes correct.
4. Back-to-back: result_valid held high with inputs changed mid-frame -> first frame carries the values captured at its handshake; second frame starts after exactly one idle-high cycle; no inter-byte gaps; exactly two handshakes over 2×30380+1 cycles.
5. Reset mid-frame during byte 5, data bit 3:
   - uart_txd=1 asynchronously;
   - after release, result_ready=1;
   - the next accepted result yields a complete, correct frame starting with 0xAA.
6. Parameter check with CLK_FREQ=1000000, UART_BPS=100000, NUM_CLASS=2 -> bit period 10 clocks, frame 6 bytes (60 bits, 600 clocks), checksum over class+2 scores.

Source files
------------

// File: rtl/mnist_result_uart_tx.sv
// Serialises one MNIST classification result as a framed 8N1 UART packet:
// AA 55 {0,class} score[0..N-1] checksum, LSB first, bytes back-to-back.
module mnist_result_uart_tx #(
  parameter int CLK_FREQ  = 25000000,
  parameter int UART_BPS  = 115200,
  parameter int NUM_CLASS = 10
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   result_valid,
  output logic                   result_ready,
  input  logic [3:0]             result_class,
  input  logic [8*NUM_CLASS-1:0] result_scores,
  output logic                   uart_txd,
  output logic                   tx_busy
);

  localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
  localparam int CNT_W     = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int NUM_BYTES = NUM_CLASS + 4;
  localparam int IDX_W     = $clog2(NUM_BYTES);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 8-bit wrapping sum of class and all scores; header bytes excluded.
  function automatic logic [7:0] frame_checksum(
    input logic [3:0]             cls,
    input logic [8*NUM_CLASS-1:0] scores
  );
    logic [7:0] acc;
    acc = {4'h0, cls};
    for (int k = 0; k < NUM_CLASS; k++) begin
      acc = acc + scores[8*k +: 8];
    end
    return acc;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       frame_mem [NUM_BYTES];

  logic             accept;
  logic             bit_end;
  logic [7:0]       cur_byte;
  logic [2:0]       next_bit;

  // Handshake qualifier, end-of-bit strobe and current byte/bit selection.
  always_comb begin
    accept   = result_valid && result_ready;
    bit_end  = (baud_cnt == BAUD_LAST);
    cur_byte = frame_mem[byte_idx];
    next_bit = bit_idx + 3'd1;
  end

  // Snapshot the whole frame at the handshake so later input changes are ignored.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        frame_mem[k] <= 8'h00;
      end
    end else if (accept) begin
      frame_mem[0] <= 8'hAA;
      frame_mem[1] <= 8'h55;
      frame_mem[2] <= {4'h0, result_class};
      for (int k = 0; k < NUM_CLASS; k++) begin
        frame_mem[k+3] <= result_scores[8*k +: 8];
      end
      frame_mem[NUM_BYTES-1] <= frame_checksum(result_class, result_scores);
    end
  end

  // Transmit FSM: bit timing, bit/byte sequencing and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      baud_cnt     <= CNT_ZERO;
      bit_idx      <= 3'd0;
      byte_idx     <= IDX_ZERO;
      uart_txd     <= 1'b1;
      result_ready <= 1'b1;
      tx_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= CNT_ZERO;
          bit_idx  <= 3'd0;
          byte_idx <= IDX_ZERO;
          if (accept) begin
            state        <= START;
            uart_txd     <= 1'b0;
            result_ready <= 1'b0;
            tx_busy      <= 1'b1;
          end else begin
            uart_txd     <= 1'b1;
            result_ready <= 1'b1;
            tx_busy      <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= CNT_ZERO;
            bit_idx  <= 3'd0;
            uart_txd <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= CNT_ZERO;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= next_bit;
              uart_txd <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= CNT_ZERO;
            if (byte_idx == LAST_BYTE) begin
              // Ready rises together with the line returning to idle.
              state        <= IDLE;
              uart_txd     <= 1'b1;
              result_ready <= 1'b1;
              tx_busy      <= 1'b0;
            end else begin
              byte_idx <= byte_idx + IDX_ONE;
              uart_txd <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: begin
          state        <= IDLE;
          baud_cnt     <= CNT_ZERO;
          uart_txd     <= 1'b1;
          result_ready <= 1'b1;
          tx_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_result_uart_tx.sv
// Directed bench for mnist_result_uart_tx: decodes the serial line cycle by
// cycle and compares each frame byte, bit timing and handshake behaviour.
module tb_mnist_result_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic        ready_a, ready_b, ready_c;
  logic        txd_a, txd_b, txd_c;
  logic        busy_a, busy_b, busy_c;
  logic [3:0]  cls = 4'h0;
  logic [79:0] scores = 80'h0;
  logic [15:0] scores_c = 16'h0;

  always #5 clk = ~clk;

  // Default parameters: 217-clock bit period, 14-byte frame.
  mnist_result_uart_tx u_dut_a (
    .sys_clk(clk), .sys_rst(rst), .result_valid(valid_a), .result_ready(ready_a),
    .result_class(cls), .result_scores(scores), .uart_txd(txd_a), .tx_busy(busy_a)
  );

  // Fast baud (10-clock bit) instance for the longer scenarios.
  mnist_result_uart_tx #(.CLK_FREQ(25000000), .UART_BPS(2500000), .NUM_CLASS(10)) u_dut_b (
    .sys_clk(clk), .sys_rst(rst), .result_valid(valid_b), .result_ready(ready_b),
    .result_class(cls), .result_scores(scores), .uart_txd(txd_b), .tx_busy(busy_b)
  );

  mnist_result_uart_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .NUM_CLASS(2)) u_dut_c (
    .sys_clk(clk), .sys_rst(rst), .result_valid(valid_c), .result_ready(ready_c),
    .result_class(cls), .result_scores(scores_c), .uart_txd(txd_c), .tx_busy(busy_c)
  );

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int hs_b = 0;
  logic mon_txd, mon_ready, mon_busy;

  logic [7:0] rx_bytes  [16];
  logic [7:0] exp_bytes [16];
  int rx_timing_err, rx_frame_err, rx_hs_err;
  logic rx_first;

  always_comb begin
    case (sel)
      0:       begin mon_txd = txd_a; mon_ready = ready_a; mon_busy = busy_a; end
      1:       begin mon_txd = txd_b; mon_ready = ready_b; mon_busy = busy_b; end
      default: begin mon_txd = txd_c; mon_ready = ready_c; mon_busy = busy_c; end
    endcase
  end

  always @(posedge clk) if (valid_b && ready_b) hs_b++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(mon_ready), 32'd1);
    check({tag, "_busy"},  32'(mon_busy),  32'd0);
    check({tag, "_txd"},   32'(mon_txd),   32'd1);
  endtask

  task automatic build_exp(input logic [3:0] c, input logic [79:0] s, input int ncls);
    logic [7:0] sum;
    sum = {4'h0, c};
    exp_bytes[0] = 8'hAA;
    exp_bytes[1] = 8'h55;
    exp_bytes[2] = {4'h0, c};
    for (int k = 0; k < ncls; k++) begin
      exp_bytes[k+3] = s[8*k +: 8];
      sum = sum + s[8*k +: 8];
    end
    exp_bytes[ncls+3] = sum;
  endtask

  // Called just after the handshake edge; samples every cycle of the frame.
  task automatic rx_frame(input int nbytes, input int bps);
    logic cur;
    int bitn, posn, byten, bpos;
    rx_timing_err = 0; rx_frame_err = 0; rx_hs_err = 0;
    for (int i = 0; i < 16; i++) rx_bytes[i] = 8'h00;
    cur = 1'b1;
    for (int c = 0; c < nbytes*10*bps; c++) begin
      @(negedge clk);
      if (c == 0) rx_first = mon_txd;
      bitn = c / bps; posn = c % bps; byten = bitn / 10; bpos = bitn % 10;
      if (posn == 0) begin
        cur = mon_txd;
        if (bpos == 0) begin
          if (cur !== 1'b0) rx_frame_err++;
        end else if (bpos == 9) begin
          if (cur !== 1'b1) rx_frame_err++;
        end else begin
          rx_bytes[byten][bpos-1] = cur;
        end
      end else if (mon_txd !== cur) begin
        rx_timing_err++;
      end
      if (mon_ready !== 1'b0 || mon_busy !== 1'b1) rx_hs_err++;
    end
  endtask

  task automatic check_frame(input string tag, input int nbytes);
    for (int i = 0; i < nbytes; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_bytes[i]), 32'(exp_bytes[i]));
    check({tag, "_timing"}, rx_timing_err, 0);
    check({tag, "_framing"}, rx_frame_err, 0);
    check({tag, "_busy_during"}, rx_hs_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    // 1. Reset at a random phase; outputs must go idle immediately.
    #($urandom_range(3, 17));
    rst = 1'b1;
    #1;
    sel = 0; check_idle("t1_async_a");
    sel = 1; check_idle("t1_async_b");
    sel = 2; check_idle("t1_async_c");
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    sel = 0; check_idle("t1_hold_a");

    // 2. Single frame at default parameters.
    cls = 4'd7; scores = 80'h09080706050403020100;
    build_exp(cls, scores, 10);
    valid_a = 1'b1;
    check_idle("t2_pre");
    @(posedge clk); #1 valid_a = 1'b0;
    rx_frame(14, 217);
    check("t2_start_bit", 32'(rx_first), 32'd0);
    check("t2_csum_const", 32'(rx_bytes[13]), 32'h34);
    check_frame("t2", 14);
    @(negedge clk) check_idle("t2_done");

    // 3. Checksum wrap.
    sel = 1;
    cls = 4'd9; scores = {80{1'b1}};
    build_exp(cls, scores, 10);
    valid_b = 1'b1;
    @(posedge clk); #1 valid_b = 1'b0;
    rx_frame(14, 10);
    check("t3_csum_const", 32'(rx_bytes[13]), 32'hFF);
    check("t3_class_const", 32'(rx_bytes[2]), 32'h09);
    check_frame("t3", 14);
    @(negedge clk) check_idle("t3_done");

    // 4. Back-to-back with valid held and inputs changed mid-frame.
    cls = 4'd3; scores = 80'h19181716151413121110;
    build_exp(cls, scores, 10);
    valid_b = 1'b1;
    h0 = hs_b;
    @(posedge clk);
    fork
      rx_frame(14, 10);
      begin
        repeat (300) @(negedge clk);
        cls = 4'd5; scores = 80'h29282726252423222120;
      end
    join
    check("t4a_csum_const", 32'(rx_bytes[13]), 32'hD0);
    check_frame("t4a", 14);
    @(negedge clk) check_idle("t4_gap");
    build_exp(cls, scores, 10);
    fork
      rx_frame(14, 10);
      begin @(posedge clk); #1 valid_b = 1'b0; end
    join
    check("t4b_start_bit", 32'(rx_first), 32'd0);
    check("t4b_csum_const", 32'(rx_bytes[13]), 32'h72);
    check_frame("t4b", 14);
    check("t4_handshakes", hs_b - h0, 2);
    @(negedge clk) check_idle("t4_done");

    // 5. Reset during byte 5, data bit 3 (score[2]=0x22, that bit is 0).
    cls = 4'd1; scores = 80'h99887766554433221100;
    valid_b = 1'b1;
    @(posedge clk); #1 valid_b = 1'b0;
    repeat (545) @(negedge clk);
    check("t5_pre_txd", 32'(txd_b), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t5_async_txd", 32'(txd_b), 32'd1);
    check("t5_async_busy", 32'(busy_b), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk) check_idle("t5_release");
    cls = 4'd2; scores = 80'h0A0B0C0D0E0F10111213;
    build_exp(cls, scores, 10);
    valid_b = 1'b1;
    @(posedge clk); #1 valid_b = 1'b0;
    rx_frame(14, 10);
    check("t5_first_aa", 32'(rx_bytes[0]), 32'hAA);
    check_frame("t5", 14);
    @(negedge clk) check_idle("t5_done");

    // 6. Small parameter set: 10-clock bits, 6-byte frame, class sent unchanged.
    sel = 2;
    cls = 4'hC; scores_c = 16'h9080;
    build_exp(cls, {64'h0, scores_c}, 2);
    valid_c = 1'b1;
    @(posedge clk); #1 valid_c = 1'b0;
    rx_frame(6, 10);
    check("t6_class_const", 32'(rx_bytes[2]), 32'h0C);
    check("t6_csum_const", 32'(rx_bytes[5]), 32'h1C);
    check_frame("t6", 6);
    @(negedge clk) check_idle("t6_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
